ws2812b_chain: RTL and testbench

WS2812B_CHAIN -- requirements
Module: ws2812b_chain

---
 rtl/ws2812b_pkg.sv | 27 ++
 rtl/ws2812b_bit_timer.sv | 43 ++++
 rtl/ws2812b_chain.sv | 157 +++++++++++++++
 tb/tb_ws2812b_chain.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// WS2812B chain driver: shared types, cycle-count helpers and GRB color constants.
package ws2812b_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    localparam logic [23:0] RED    = 24'h00FF00;
    localparam logic [23:0] GREEN  = 24'hFF0000;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] CYAN   = 24'hFF00FF;
    localparam logic [23:0] ORANGE = 24'h80FF00;
    localparam logic [23:0] OFF    = 24'h000000;

    function automatic int ns_to_cyc(input int mhz, input int ns);
        return (mhz * ns + 500) / 1000;
    endfunction

    function automatic int us_to_cyc(input int mhz, input int us);
        return mhz * us;
    endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// WS2812B bit timer: one counter spans the HIGH and LOW phase of a single bit.
module ws2812b_bit_timer
    import ws2812b_pkg::*;
#(
    parameter int T0H = 11,
    parameter int T1H = 22,
    parameter int BIT = 34
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic bit_val,
    input  logic short_bit,
    output logic high_done,
    output logic bit_done
);

    localparam int CW = $clog2(BIT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] t_high;
    logic [CW-1:0] t_end;

    // short_bit gives up the final low cycle to the LOAD slot of the next LED
    always_comb begin
        t_high = bit_val ? CW'(T1H - 1) : CW'(T0H - 1);
        t_end  = short_bit ? CW'(BIT - 2) : CW'(BIT - 1);
    end

    assign high_done = en && (cnt == t_high);
    assign bit_done  = en && (cnt == t_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812b_chain.sv
// WS2812B chain driver: color store, frame FSM and registered serial output.
module ws2812b_chain
    import ws2812b_pkg::*;
#(
    parameter int CLOCK_MHZ    = 27,
    parameter int NUM_LEDS     = 8,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int BIT_NS       = 1250,
    parameter int RESET_US     = 80,
    parameter int AUTO_REFRESH = 0,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dout
);

    localparam int T0H  = ns_to_cyc(CLOCK_MHZ, T0H_NS);
    localparam int T1H  = ns_to_cyc(CLOCK_MHZ, T1H_NS);
    localparam int BIT  = ns_to_cyc(CLOCK_MHZ, BIT_NS);
    localparam int TRST = us_to_cyc(CLOCK_MHZ, RESET_US);
    localparam int LW   = $clog2(TRST + 1);

    localparam logic [AW:0]   N_LEDS   = (AW + 1)'(NUM_LEDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);

    logic [23:0]   color [NUM_LEDS];
    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] led_idx;
    logic [4:0]    bit_cnt;
    logic [23:0]   shifter;
    logic [LW-1:0] lat_cnt;
    logic [1:0]    fin_q;
    logic          last_bit;
    logic          last_led;
    logic          lat_end;
    logic          timer_en;
    logic          high_done;
    logic          bit_done;

    assign last_bit = (bit_cnt == 5'd0);
    assign last_led = (led_idx == LAST_IDX);
    assign timer_en = (state == ST_HIGH) || (state == ST_LOW);
    // LATCH runs one short; the following IDLE/LOAD cycle is the last low one
    assign lat_end  = (state == ST_LATCH) && (lat_cnt == LW'(TRST - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                color[i] <= OFF;
            end
        end else if (wr_en && ({1'b0, wr_addr} < N_LEDS)) begin
            color[wr_addr] <= wr_data;
        end
    end

    ws2812b_bit_timer #(
        .T0H (T0H),
        .T1H (T1H),
        .BIT (BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (timer_en),
        .bit_val   (shifter[23]),
        .short_bit (last_bit && !last_led),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !busy) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nx = ST_HIGH;
            end
            ST_HIGH: begin
                if (high_done) begin
                    state_nx = ST_LOW;
                end
            end
            ST_LOW: begin
                if (bit_done) begin
                    if (!last_bit) begin
                        state_nx = ST_HIGH;
                    end else if (!last_led) begin
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_end) begin
                    state_nx = (AUTO_REFRESH != 0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // dout trails the FSM by one cycle; done/busy-fall are delayed to match it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            led_idx <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            lat_cnt <= '0;
            fin_q   <= '0;
        end else begin
            state   <= state_nx;
            dout    <= (state == ST_HIGH);
            fin_q   <= {fin_q[0], lat_end};
            done    <= fin_q[1];
            lat_cnt <= (state == ST_LATCH) ? lat_cnt + 1'b1 : '0;
            if ((state == ST_IDLE) && start && !busy) begin
                busy <= 1'b1;
            end else if (fin_q[1] && (AUTO_REFRESH == 0)) begin
                busy <= 1'b0;
            end
            if (state == ST_LOAD) begin
                shifter <= color[led_idx];
                bit_cnt <= 5'd23;
            end else if ((state == ST_LOW) && bit_done) begin
                if (!last_bit) begin
                    shifter <= {shifter[22:0], 1'b0};
                    bit_cnt <= bit_cnt - 1'b1;
                end else if (!last_led) begin
                    led_idx <= led_idx + 1'b1;
                end
            end
            if (lat_end) begin
                led_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_chain.sv
// Directed bench for ws2812b_chain: 2-LED, auto-refresh and 50 MHz instances.
module tb_ws2812b_chain;
    import ws2812b_pkg::*;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b000;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  wr_en_v = 3'b000;
    logic [1:0]  wr_addr_v [3];
    logic [23:0] wr_data_v [3];
    logic [2:0]  dout_w;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812b_chain #(.NUM_LEDS(2)) u0 (
        .clk(clk), .rst_n(rst_v[0]), .wr_en(wr_en_v[0]),
        .wr_addr(wr_addr_v[0][0:0]), .wr_data(wr_data_v[0]),
        .start(start_v[0]), .busy(busy_w[0]), .done(done_w[0]),
        .dout(dout_w[0])
    );

    ws2812b_chain #(.NUM_LEDS(1), .AUTO_REFRESH(1)) u1 (
        .clk(clk), .rst_n(rst_v[1]), .wr_en(wr_en_v[1]),
        .wr_addr(wr_addr_v[1][0:0]), .wr_data(wr_data_v[1]),
        .start(start_v[1]), .busy(busy_w[1]), .done(done_w[1]),
        .dout(dout_w[1])
    );

    ws2812b_chain #(.CLOCK_MHZ(50), .NUM_LEDS(3)) u2 (
        .clk(clk), .rst_n(rst_v[2]), .wr_en(wr_en_v[2]),
        .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]),
        .start(start_v[2]), .busy(busy_w[2]), .done(done_w[2]),
        .dout(dout_w[2])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [23:0] v);
        wr_en_v[d] = 1'b1;
        wr_addr_v[d] = a;
        wr_data_v[d] = v;
        @(negedge clk);
        wr_en_v[d] = 1'b0;
    endtask

    // start pulse sampled at edge k; dout must be low at k, k+1 and high at k+2
    task automatic kick(input int d);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        check1($sformatf("d%0d busy_rise", d), busy_w[d], 1'b1);
        check1($sformatf("d%0d dout_k", d), dout_w[d], 1'b0);
        @(negedge clk);
        check1($sformatf("d%0d dout_k1", d), dout_w[d], 1'b0);
        @(negedge clk);
        check1($sformatf("d%0d dout_k2", d), dout_w[d], 1'b1);
    endtask

    task automatic adv(input int d, inout int dn);
        @(negedge clk);
        start_v[d] = 1'b0;
        wr_en_v[d] = 1'b0;
        if (done_w[d] === 1'b1) dn++;
    endtask

    // entered on the first high sample of a frame
    task automatic run_frame(input int d, input int n,
                             input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2, input int th0,
                             input int th1, input int tb, input int tr,
                             input bit autom, input int inj);
        int t0, hi, lo, dn, idx, exp_hi;
        bit last;
        logic [23:0] w;
        t0 = cyc;
        dn = 0;
        for (int l = 0; l < n; l++) begin
            w = (l == 0) ? w0 : (l == 1) ? w1 : w2;
            for (int b = 23; b >= 0; b--) begin
                idx = l * 24 + 23 - b;
                last = (idx == n * 24 - 1);
                exp_hi = w[b] ? th1 : th0;
                if (idx == inj) begin
                    start_v[d] = 1'b1;
                    wr_en_v[d] = 1'b1;
                    wr_addr_v[d] = 2'd0;
                    wr_data_v[d] = RED;
                end
                hi = 0;
                while (dout_w[d] === 1'b1 && hi < 1000) begin
                    hi++;
                    adv(d, dn);
                end
                lo = 0;
                while (dout_w[d] !== 1'b1 && lo < tb + tr + 10 &&
                       !(last && done_w[d] === 1'b1)) begin
                    lo++;
                    adv(d, dn);
                end
                check($sformatf("d%0d led%0d bit%0d high", d, l, b), hi, exp_hi);
                if (!last) begin
                    check($sformatf("d%0d led%0d bit%0d low", d, l, b), lo, tb - exp_hi);
                end else begin
                    check($sformatf("d%0d latch_low", d), lo, tb - exp_hi + tr);
                    check1($sformatf("d%0d done_at_end", d), done_w[d], 1'b1);
                    check1($sformatf("d%0d busy_at_end", d), busy_w[d], autom);
                end
            end
        end
        check($sformatf("d%0d frame_len", d), cyc - t0, n * 24 * tb + tr);
        check($sformatf("d%0d done_count", d), dn, 1);
        if (!autom) begin
            @(negedge clk);
            check1($sformatf("d%0d done_width", d), done_w[d], 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr_addr_v[i] = 2'd0;
            wr_data_v[i] = OFF;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check1($sformatf("d%0d rst_dout", d), dout_w[d], 1'b0);
            check1($sformatf("d%0d rst_busy", d), busy_w[d], 1'b0);
            check1($sformatf("d%0d rst_done", d), done_w[d], 1'b0);
        end
        rst_v = 3'b111;
        @(negedge clk);

        // frame A with mid-frame start and LED0 rewrite at bit index 5
        wr(0, 2'd0, CYAN);
        wr(0, 2'd1, 24'h000001);
        kick(0);
        run_frame(0, 2, CYAN, 24'h000001, OFF, 11, 22, 34, 2160, 1'b0, 5);
        repeat (20) @(negedge clk);
        check1("d0 no_restart_busy", busy_w[0], 1'b0);
        check1("d0 no_restart_dout", dout_w[0], 1'b0);

        // frame B carries the rewritten LED0
        kick(0);
        run_frame(0, 2, RED, 24'h000001, OFF, 11, 22, 34, 2160, 1'b0, -1);

        // reset inside bit 10 (LED0 bit 13 = 1, high for 22 cycles)
        kick(0);
        repeat (10 * 34 + 3) @(negedge clk);
        check1("d0 pre_reset_dout", dout_w[0], 1'b1);
        #2 rst_v[0] = 1'b0;
        #1;
        check1("d0 reset_dout", dout_w[0], 1'b0);
        check1("d0 reset_busy", busy_w[0], 1'b0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        kick(0);
        run_frame(0, 2, OFF, OFF, OFF, 11, 22, 34, 2160, 1'b0, -1);

        // auto refresh: two back-to-back frames from one start
        wr(1, 2'd0, BLUE);
        kick(1);
        run_frame(1, 1, BLUE, OFF, OFF, 11, 22, 34, 2160, 1'b1, -1);
        run_frame(1, 1, BLUE, OFF, OFF, 11, 22, 34, 2160, 1'b1, -1);
        rst_v[1] = 1'b0;

        // 50 MHz timing, out-of-range write ignored
        wr(2, 2'd0, RED);
        wr(2, 2'd1, CYAN);
        wr(2, 2'd2, ORANGE);
        wr(2, 2'd3, 24'hFFFFFF);
        kick(2);
        run_frame(2, 3, RED, CYAN, ORANGE, 20, 40, 63, 4000, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
